// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding ALU_Top.
// Captures decoded operands and control, builds the 4-bit ALU_ctrl at
// capture time, and drives input_1/input_2/ALU_ctrl one cycle after decode.
// Optional macro ID_EX_FWD_EN: when defined, EX/MEM and MEM/WB results are
// forwarded onto the operands; when undefined the forward ports are ignored
// and operands come only from the registered register-file data.
//
// Flow control: ex_valid qualifies everything held in the stage. There is
// no ready signal; the hazard unit applies backpressure with stall (hold
// contents) and inserts bubbles with flush (flush has priority over stall).

module id_ex_stage #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_alu_src,
    input  logic [1:0]        id_alu_op,
    input  logic [10:0]       id_opcode,
    input  logic [REG_W-1:0]  id_rn,
    input  logic [REG_W-1:0]  id_rm,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              id_reg_write,
    input  logic              exmem_reg_write,
    input  logic [REG_W-1:0]  exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_W-1:0]  memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic              ex_valid,
    output logic [DATA_W-1:0] input_1,
    output logic [DATA_W-1:0] input_2,
    output logic [3:0]        ALU_ctrl,
    output logic [REG_W-1:0]  ex_rd,
    output logic              ex_reg_write
);

    // Highest register index is the zero register (XZR).
    localparam logic [REG_W-1:0] XZR      = '1;
    localparam logic [3:0]       CTRL_NOP = 4'b1111;

    logic              r_valid;
    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;
    logic [DATA_W-1:0] r_imm;
    logic              r_alu_src;
    logic [1:0]        r_alu_op;
    logic [REG_W-1:0]  r_rn;
    logic [REG_W-1:0]  r_rm;
    logic [REG_W-1:0]  r_rd;
    logic              r_reg_write;
    logic [3:0]        r_alu_ctrl;

    logic [3:0]        next_ctrl;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    // ALU control derived from ALUOp and, for R-type, the opcode field.
    function automatic logic [3:0] decode_ctrl(input logic [1:0]  alu_op,
                                               input logic [10:0] opcode);
        logic [3:0] ctrl;
        ctrl = CTRL_NOP;
        case (alu_op)
            2'b00: ctrl = 4'b0010;
            2'b01: ctrl = 4'b0110;
            2'b10: begin
                case (opcode)
                    11'b10001011000: ctrl = 4'b0010;
                    11'b11001011000: ctrl = 4'b0110;
                    11'b10001010000: ctrl = 4'b0000;
                    11'b10101010000: ctrl = 4'b0001;
                    11'b10011011000: ctrl = 4'b0111;
                    11'b10011010110: ctrl = 4'b0011;
                    default:         ctrl = CTRL_NOP;
                endcase
            end
            default: ctrl = CTRL_NOP;
        endcase
        return ctrl;
    endfunction

    // Control for the instruction being captured; invalid slots become nops.
    always_comb begin
        next_ctrl = CTRL_NOP;
        if (id_valid) begin
            next_ctrl = decode_ctrl(id_alu_op, id_opcode);
        end
    end

    // Pipeline register: flush inserts a bubble, stall holds, else capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_rd1       <= '0;
            r_rd2       <= '0;
            r_imm       <= '0;
            r_alu_src   <= 1'b0;
            r_alu_op    <= 2'b00;
            r_rn        <= '0;
            r_rm        <= '0;
            r_rd        <= '0;
            r_reg_write <= 1'b0;
            r_alu_ctrl  <= CTRL_NOP;
        end else if (flush) begin
            r_valid     <= 1'b0;
            r_rd1       <= '0;
            r_rd2       <= '0;
            r_imm       <= '0;
            r_alu_src   <= 1'b0;
            r_alu_op    <= 2'b00;
            r_rn        <= '0;
            r_rm        <= '0;
            r_rd        <= '0;
            r_reg_write <= 1'b0;
            r_alu_ctrl  <= CTRL_NOP;
        end else if (!stall) begin
            r_valid     <= id_valid;
            r_rd1       <= id_rd1;
            r_rd2       <= id_rd2;
            r_imm       <= id_imm;
            r_alu_src   <= id_alu_src;
            r_alu_op    <= id_alu_op;
            r_rn        <= id_rn;
            r_rm        <= id_rm;
            r_rd        <= id_rd;
            r_reg_write <= id_reg_write;
            r_alu_ctrl  <= next_ctrl;
        end
    end

`ifdef ID_EX_FWD_EN
    // Operand source value: XZR reads zero, then EX/MEM, then MEM/WB, then regfile.
    function automatic logic [DATA_W-1:0] src_value(
        input logic [REG_W-1:0]  src,
        input logic [DATA_W-1:0] reg_val,
        input logic              em_we,
        input logic [REG_W-1:0]  em_rd,
        input logic [DATA_W-1:0] em_res,
        input logic              mw_we,
        input logic [REG_W-1:0]  mw_rd,
        input logic [DATA_W-1:0] mw_res
    );
        logic [DATA_W-1:0] val;
        val = reg_val;
        if (src == XZR)                   val = '0;
        else if (em_we && (em_rd == src)) val = em_res;
        else if (mw_we && (mw_rd == src)) val = mw_res;
        return val;
    endfunction

    // Forwarded operands, re-evaluated every cycle from the live forward inputs.
    always_comb begin
        op_a = src_value(r_rn, r_rd1, exmem_reg_write, exmem_rd, exmem_result,
                         memwb_reg_write, memwb_rd, memwb_result);
        op_b = src_value(r_rm, r_rd2, exmem_reg_write, exmem_rd, exmem_result,
                         memwb_reg_write, memwb_rd, memwb_result);
    end
`else
    // Forward ports have no effect in this build.
    logic unused_fwd;
    assign unused_fwd = ^{exmem_reg_write, exmem_rd, exmem_result,
                          memwb_reg_write, memwb_rd, memwb_result};

    // Operands straight from the registered regfile data, XZR reads zero.
    always_comb begin
        op_a = (r_rn == XZR) ? '0 : r_rd1;
        op_b = (r_rm == XZR) ? '0 : r_rd2;
    end
`endif

    // ALU-facing outputs: CBZ zeroes operand A, alu_src selects the immediate.
    always_comb begin
        input_1      = (r_alu_op == 2'b01) ? '0 : op_a;
        input_2      = r_alu_src ? r_imm : op_b;
        ALU_ctrl     = r_alu_ctrl;
        ex_valid     = r_valid;
        ex_rd        = r_rd;
        ex_reg_write = r_reg_write & r_valid;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized checks of id_ex_stage against a
// behavioural model of the stage contents (flush/stall/capture rules,
// ALU control table, forwarding priority, XZR, CBZ and immediate rules).
module tb_id_ex_stage;
  localparam int DATA_W = 64;
  localparam int REG_W  = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              id_valid = 1'b0;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  logic [DATA_W-1:0] id_rd1 = '0;
  logic [DATA_W-1:0] id_rd2 = '0;
  logic [DATA_W-1:0] id_imm = '0;
  logic              id_alu_src = 1'b0;
  logic [1:0]        id_alu_op = 2'b00;
  logic [10:0]       id_opcode = '0;
  logic [REG_W-1:0]  id_rn = '0;
  logic [REG_W-1:0]  id_rm = '0;
  logic [REG_W-1:0]  id_rd = '0;
  logic              id_reg_write = 1'b0;
  logic              exmem_reg_write = 1'b0;
  logic [REG_W-1:0]  exmem_rd = '0;
  logic [DATA_W-1:0] exmem_result = '0;
  logic              memwb_reg_write = 1'b0;
  logic [REG_W-1:0]  memwb_rd = '0;
  logic [DATA_W-1:0] memwb_result = '0;
  logic              ex_valid;
  logic [DATA_W-1:0] input_1;
  logic [DATA_W-1:0] input_2;
  logic [3:0]        ALU_ctrl;
  logic [REG_W-1:0]  ex_rd;
  logic              ex_reg_write;

  id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .stall(stall), .flush(flush),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_alu_src(id_alu_src),
    .id_alu_op(id_alu_op), .id_opcode(id_opcode), .id_rn(id_rn), .id_rm(id_rm),
    .id_rd(id_rd), .id_reg_write(id_reg_write),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .input_1(input_1), .input_2(input_2), .ALU_ctrl(ALU_ctrl),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write)
  );

  // clock / reset
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // R-type opcode -> ALU control table
  logic [10:0] opc_tbl [6] = '{11'b10001011000, 11'b11001011000, 11'b10001010000,
                               11'b10101010000, 11'b10011011000, 11'b10011010110};
  logic [3:0]  ctrl_tbl [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b0011};

  // model of what the stage holds; 'known' is 0 after a bubble, whose
  // operand fields carry no meaning
  typedef struct {
    logic              valid;
    logic              known;
    logic [DATA_W-1:0] rd1, rd2, imm;
    logic              alu_src;
    logic [1:0]        op;
    logic [10:0]       opc;
    logic [REG_W-1:0]  rn, rm, rd;
    logic              reg_write;
  } ex_t;
  ex_t m;

  task automatic model_reset();
    m.valid = 0; m.known = 1; m.rd1 = '0; m.rd2 = '0; m.imm = '0; m.alu_src = 0;
    m.op = 2'b00; m.opc = '0; m.rn = '0; m.rm = '0; m.rd = '0; m.reg_write = 0;
  endtask

  task automatic model_capture();
    if (flush) begin
      m.valid = 0; m.reg_write = 0; m.known = 0;
    end else if (!stall) begin
      m.valid = id_valid; m.known = 1; m.rd1 = id_rd1; m.rd2 = id_rd2; m.imm = id_imm;
      m.alu_src = id_alu_src; m.op = id_alu_op; m.opc = id_opcode;
      m.rn = id_rn; m.rm = id_rm; m.rd = id_rd; m.reg_write = id_reg_write;
    end
  endtask

  function automatic logic [3:0] exp_ctrl();
    if (!m.valid) return 4'b1111;
    case (m.op)
      2'b00: return 4'b0010;
      2'b01: return 4'b0110;
      2'b10: begin
        for (int i = 0; i < 6; i++) if (opc_tbl[i] == m.opc) return ctrl_tbl[i];
        return 4'b1111;
      end
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] exp_src(input logic [REG_W-1:0] src,
                                                input logic [DATA_W-1:0] regval);
    if (src == 5'd31) return '0;
`ifdef ID_EX_FWD_EN
    if (exmem_reg_write && exmem_rd == src) return exmem_result;
    if (memwb_reg_write && memwb_rd == src) return memwb_result;
`endif
    return regval;
  endfunction

  function automatic logic [DATA_W-1:0] exp_in1();
    return (m.op == 2'b01) ? '0 : exp_src(m.rn, m.rd1);
  endfunction

  function automatic logic [DATA_W-1:0] exp_in2();
    return m.alu_src ? m.imm : exp_src(m.rm, m.rd2);
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_capture();
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [DATA_W-1:0] rd1, input logic [DATA_W-1:0] rd2,
                          input logic [DATA_W-1:0] imm, input logic src, input logic [1:0] op,
                          input logic [10:0] opc, input logic [REG_W-1:0] rn,
                          input logic [REG_W-1:0] rm, input logic [REG_W-1:0] rd, input logic rw);
    id_valid = v; id_rd1 = rd1; id_rd2 = rd2; id_imm = imm; id_alu_src = src;
    id_alu_op = op; id_opcode = opc; id_rn = rn; id_rm = rm; id_rd = rd; id_reg_write = rw;
  endtask

  task automatic set_fwd(input logic ew, input logic [REG_W-1:0] erd, input logic [DATA_W-1:0] eres,
                         input logic mw, input logic [REG_W-1:0] mrd, input logic [DATA_W-1:0] mres);
    exmem_reg_write = ew; exmem_rd = erd; exmem_result = eres;
    memwb_reg_write = mw; memwb_rd = mrd; memwb_result = mres;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (ex_valid !== 1'b0 || ALU_ctrl !== 4'b1111) begin miscompares++;
      $display("FAIL reset_hold: valid=%b ctrl=%b want 0/1111", ex_valid, ALU_ctrl); end
    @(negedge clk) rst_n = 1'b1;
    drive_id(1, 64'd6, 64'd2, 64'd0, 0, 2'b10, 11'b10001011000, 5'd1, 5'd2, 5'd9, 1);
    tick();
    vectors++; if (ex_valid !== 1'b1 || ALU_ctrl !== 4'b0010) begin miscompares++;
      $display("FAIL reset_precap: valid=%b ctrl=%b want 1/0010", ex_valid, ALU_ctrl); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    vectors++; if (ex_valid !== 1'b0 || ALU_ctrl !== 4'b1111 || ex_reg_write !== 1'b0) begin miscompares++;
      $display("FAIL reset_async: valid=%b ctrl=%b rw=%b want 0/1111/0", ex_valid, ALU_ctrl, ex_reg_write); end
    vectors++; if (input_1 !== 64'd0 || input_2 !== 64'd0 || ex_rd !== 5'd0) begin miscompares++;
      $display("FAIL reset_zero: in1=%h in2=%h rd=%0d want 0", input_1, input_2, ex_rd); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_alu_ops();
    logic [10:0] unk;
    unk = 11'b11111111111;
    for (int i = 0; i < 11; i++) begin
      logic [1:0]  op;
      logic [10:0] opc;
      logic        v;
      v = 1; op = 2'b10;
      if (i < 6) opc = opc_tbl[i];
      else opc = unk;
      if (i == 7) begin op = 2'b00; opc = 11'($urandom); end
      if (i == 8) begin op = 2'b11; opc = opc_tbl[0]; end
      if (i == 9) begin op = 2'b01; opc = 11'($urandom); end
      if (i == 10) begin v = 0; opc = opc_tbl[0]; end
      if (i == 0) drive_id(v, 64'd6, 64'd2, 64'd0, 0, op, opc, 5'd1, 5'd2, 5'd7, 1);
      else drive_id(v, {$urandom, $urandom}, {$urandom, $urandom}, 64'd0, 0, op, opc,
                    5'($urandom_range(0, 30)), 5'($urandom_range(0, 30)), 5'($urandom_range(0, 31)), 1);
      tick();
      vectors++; if (ALU_ctrl !== exp_ctrl()) begin miscompares++;
        $display("FAIL alu_ctrl[%0d]: got %b want %b", i, ALU_ctrl, exp_ctrl()); end
      vectors++; if (input_1 !== exp_in1() || input_2 !== exp_in2()) begin miscompares++;
        $display("FAIL alu_operands[%0d]: got %h/%h want %h/%h", i, input_1, input_2, exp_in1(), exp_in2()); end
      vectors++; if (ex_valid !== v || ex_reg_write !== v || ex_rd !== m.rd) begin miscompares++;
        $display("FAIL alu_flags[%0d]: valid=%b rw=%b rd=%0d want %b/%b/%0d", i, ex_valid, ex_reg_write, ex_rd, v, v, m.rd); end
    end
    // spot values from the specification's ADD example
    drive_id(1, 64'd6, 64'd2, 64'd0, 0, 2'b10, 11'b10001011000, 5'd1, 5'd2, 5'd3, 1);
    tick();
    vectors++; if (input_1 !== 64'd6 || input_2 !== 64'd2 || ALU_ctrl !== 4'b0010) begin miscompares++;
      $display("FAIL add_example: got %0d/%0d/%b want 6/2/0010", input_1, input_2, ALU_ctrl); end
  endtask

  task automatic test_forward();
    logic [DATA_W-1:0] w_both, w_mem, w_none, w_b;
`ifdef ID_EX_FWD_EN
    w_both = 64'd100; w_mem = 64'd50; w_none = 64'd7; w_b = 64'd200;
`else
    w_both = 64'd7; w_mem = 64'd7; w_none = 64'd7; w_b = 64'd8;
`endif
    drive_id(1, 64'd7, 64'd8, 64'd0, 0, 2'b10, 11'b10001011000, 5'd3, 5'd4, 5'd5, 1);
    set_fwd(1, 5'd3, 64'd100, 1, 5'd3, 64'd50);
    tick();
    vectors++; if (input_1 !== w_both) begin miscompares++;
      $display("FAIL fwd_both: got %0d want %0d", input_1, w_both); end
    exmem_reg_write = 0; #1;
    vectors++; if (input_1 !== w_mem) begin miscompares++;
      $display("FAIL fwd_memwb: got %0d want %0d", input_1, w_mem); end
    memwb_reg_write = 0; #1;
    vectors++; if (input_1 !== w_none) begin miscompares++;
      $display("FAIL fwd_none: got %0d want %0d", input_1, w_none); end
    set_fwd(1, 5'd4, 64'd200, 1, 5'd4, 64'd60); #1;
    vectors++; if (input_2 !== w_b) begin miscompares++;
      $display("FAIL fwd_opb: got %0d want %0d", input_2, w_b); end
    drive_id(1, 64'd7, 64'd8, 64'd0, 0, 2'b10, 11'b10001011000, 5'd31, 5'd4, 5'd5, 1);
    set_fwd(1, 5'd31, 64'd100, 1, 5'd31, 64'd50);
    tick();
    vectors++; if (input_1 !== 64'd0) begin miscompares++;
      $display("FAIL fwd_xzr: got %0d want 0", input_1); end
    set_fwd(0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
  endtask

  task automatic test_imm_cbz();
    set_fwd(1, 5'd3, 64'd123, 1, 5'd3, 64'd456);
    drive_id(1, 64'd5, 64'd9, -64'sd2, 1, 2'b00, 11'd0, 5'd1, 5'd3, 5'd2, 1);
    tick();
    vectors++; if (input_2 !== 64'hFFFF_FFFF_FFFF_FFFE || input_1 !== 64'd5 || ALU_ctrl !== 4'b0010) begin miscompares++;
      $display("FAIL imm: got %h/%h/%b want 5/fffffffffffffffe/0010", input_1, input_2, ALU_ctrl); end
    drive_id(1, 64'd77, 64'd0, 64'd0, 0, 2'b01, 11'($urandom), 5'd3, 5'd2, 5'd0, 0);
    tick();
    vectors++; if (input_1 !== 64'd0 || input_2 !== 64'd0 || ALU_ctrl !== 4'b0110 || ex_reg_write !== 1'b0) begin miscompares++;
      $display("FAIL cbz: got %h/%h/%b/%b want 0/0/0110/0", input_1, input_2, ALU_ctrl, ex_reg_write); end
    set_fwd(0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
  endtask

  task automatic test_stall_flush();
    drive_id(1, 64'd6, 64'd2, 64'd0, 0, 2'b10, 11'b10001011000, 5'd1, 5'd2, 5'd7, 1);
    tick();
    stall = 1;
    drive_id(1, 64'd99, 64'd98, 64'd5, 1, 2'b10, 11'b11001011000, 5'd4, 5'd5, 5'd6, 0);
    tick(); tick();
    vectors++; if (input_1 !== 64'd6 || input_2 !== 64'd2 || ALU_ctrl !== 4'b0010) begin miscompares++;
      $display("FAIL stall_ops: got %0d/%0d/%b want 6/2/0010", input_1, input_2, ALU_ctrl); end
    vectors++; if (ex_valid !== 1'b1 || ex_rd !== 5'd7 || ex_reg_write !== 1'b1) begin miscompares++;
      $display("FAIL stall_flags: got %b/%0d/%b want 1/7/1", ex_valid, ex_rd, ex_reg_write); end
    flush = 1;
    tick();
    vectors++; if (ex_valid !== 1'b0 || ALU_ctrl !== 4'b1111 || ex_reg_write !== 1'b0) begin miscompares++;
      $display("FAIL flush: got %b/%b/%b want 0/1111/0", ex_valid, ALU_ctrl, ex_reg_write); end
    stall = 0; flush = 0;
    drive_id(1, 64'd3, 64'd12, 64'd0, 0, 2'b10, 11'b10101010000, 5'd1, 5'd2, 5'd8, 1);
    tick();
    vectors++; if (ex_valid !== 1'b1 || ALU_ctrl !== 4'b0001 || input_1 !== 64'd3 || input_2 !== 64'd12) begin miscompares++;
      $display("FAIL after_flush: got %b/%b/%0d/%0d want 1/0001/3/12", ex_valid, ALU_ctrl, input_1, input_2); end
  endtask

  task automatic test_reset_mid_stall();
    drive_id(1, 64'd4, 64'd5, 64'd0, 0, 2'b10, 11'b10011011000, 5'd1, 5'd2, 5'd9, 1);
    tick();
    stall = 1;
    tick();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    vectors++; if (ex_valid !== 1'b0 || ALU_ctrl !== 4'b1111 || ex_rd !== 5'd0 || ex_reg_write !== 1'b0) begin miscompares++;
      $display("FAIL rst_stall: got %b/%b/%0d/%b want 0/1111/0/0", ex_valid, ALU_ctrl, ex_rd, ex_reg_write); end
    @(negedge clk) rst_n = 1'b1;
    tick();
    vectors++; if (ex_valid !== 1'b0 || ALU_ctrl !== 4'b1111) begin miscompares++;
      $display("FAIL rst_stall_hold: got %b/%b want 0/1111", ex_valid, ALU_ctrl); end
    stall = 0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [10:0] opc;
      opc = ($urandom_range(0, 3) != 0) ? opc_tbl[$urandom_range(0, 5)] : 11'($urandom);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      drive_id(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
               1'($urandom), 2'($urandom), opc,
               ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 7)),
               ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 7)),
               5'($urandom), 1'($urandom));
      set_fwd(1'($urandom), 5'($urandom_range(0, 7)), {$urandom, $urandom},
              1'($urandom), 5'($urandom_range(0, 7)), {$urandom, $urandom});
      tick();
      vectors++; if (ex_valid !== m.valid || ALU_ctrl !== exp_ctrl() || ex_reg_write !== (m.valid & m.reg_write)) begin miscompares++;
        $display("FAIL rand_ctl[%0d]: got %b/%b/%b want %b/%b/%b", n, ex_valid, ALU_ctrl, ex_reg_write,
                 m.valid, exp_ctrl(), m.valid & m.reg_write); end
      if (m.known) begin
        vectors++; if (input_1 !== exp_in1() || input_2 !== exp_in2() || ex_rd !== m.rd) begin miscompares++;
          $display("FAIL rand_ops[%0d]: got %h/%h/%0d want %h/%h/%0d", n, input_1, input_2, ex_rd,
                   exp_in1(), exp_in2(), m.rd); end
        set_fwd(1'($urandom), 5'($urandom_range(0, 7)), {$urandom, $urandom},
                1'($urandom), 5'($urandom_range(0, 7)), {$urandom, $urandom});
        #1;
        vectors++; if (input_1 !== exp_in1() || input_2 !== exp_in2()) begin miscompares++;
          $display("FAIL rand_live_fwd[%0d]: got %h/%h want %h/%h", n, input_1, input_2, exp_in1(), exp_in2()); end
      end
    end
    stall = 0; flush = 0;
    set_fwd(0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_alu_ops();
    test_forward();
    test_imm_cbz();
    test_stall_flush();
    test_reset_mid_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
